// File: rtl/pixel_frame_sink.sv
// pixel_frame_sink
// ----------------
// Receiving end of the pixel-plot interface. Single-pixel writes land in a
// 160x120 x 3-bit frame buffer. The buffer is scanned out continuously as
// 640x480@60 VGA, with each stored pixel replicated 4x4.
//
// Optional feature macro: FRAME_CLEAR_EN
//   defined   : after reset release a clear engine writes CLEAR_COLOUR to
//               every location (one per clk); busy is high and plots are
//               ignored while it runs.
//   undefined : no clear engine, busy tied low, buffer kept across reset.
//
// Ports
//   clk          in   50 MHz system clock
//   resetn       in   synchronous active-low reset
//   plot         in   write strobe, one pixel per asserted cycle
//   x [7:0]      in   column, 0..159 (others dropped)
//   y [6:0]      in   row, 0..119 (others dropped)
//   colour [2:0] in   {R,G,B}
//   busy         out  clear engine running
//   vga_clk      out  25 MHz pixel clock (phase register)
//   vga_hs/vs    out  active-low syncs
//   vga_blank_n  out  low outside the visible area
//   vga_sync_n   out  constant 0
//   vga_r/g/b    out  channel bit replicated to 10 bits, 0 when blanked
module pixel_frame_sink #(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    output logic        busy,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [9:0]  vga_r,
    output logic [9:0]  vga_g,
    output logic [9:0]  vga_b
);

    localparam logic [9:0]  H_VIS    = 10'd640;
    localparam logic [9:0]  H_SYNC_S = 10'd656;
    localparam logic [9:0]  H_SYNC_E = 10'd752;
    localparam logic [9:0]  H_LAST   = 10'd799;
    localparam logic [9:0]  V_VIS    = 10'd480;
    localparam logic [9:0]  V_SYNC_S = 10'd490;
    localparam logic [9:0]  V_SYNC_E = 10'd492;
    localparam logic [9:0]  V_LAST   = 10'd524;
    localparam logic [14:0] ADDR_LAST = 15'd19199;

    logic [2:0]  mem_q [0:19199];
    logic [2:0]  rd_data_q;
    logic [14:0] rd_addr_s;
    logic        wr_en_s;
    logic [14:0] wr_addr_s;
    logic [2:0]  wr_data_s;
    logic        plot_ok_s;
    logic [14:0] plot_addr_s;
    logic        busy_s;

    logic        ph_q, ph_d;
    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [2:0]  rgb_q, rgb_d;

    // y*160 + x as y*128 + y*32 + x
    assign plot_addr_s = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    assign plot_ok_s   = plot && (x < 8'd160) && (y < 7'd120);

    // Scan address; parked at 0 outside the visible area so it never leaves the array
    assign rd_addr_s = ((h_q < H_VIS) && (v_q < V_VIS))
                     ? (({7'd0, v_q[9:2]} << 7) + ({7'd0, v_q[9:2]} << 5) + {7'd0, h_q[9:2]})
                     : 15'd0;

`ifdef FRAME_CLEAR_EN
    logic [14:0] clr_addr_q, clr_addr_d;
    logic        busy_q, busy_d;

    // Clear engine next state: walk addresses 0..19199 once, then drop busy
    always_comb begin
        busy_d     = busy_q;
        clr_addr_d = clr_addr_q;
        if (busy_q) begin
            if (clr_addr_q == ADDR_LAST) begin
                busy_d = 1'b0;
            end else begin
                clr_addr_d = clr_addr_q + 15'd1;
            end
        end else begin
            clr_addr_d = clr_addr_q;
        end
    end

    // Clear engine state register; every reset restarts the clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q     <= 1'b1;
            clr_addr_q <= 15'd0;
        end else begin
            busy_q     <= busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy_s = busy_q;

    // Write port mux: the clear engine owns the port while busy
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = plot_addr_s;
        wr_data_s = colour;
        if (busy_q) begin
            wr_en_s   = resetn;
            wr_addr_s = clr_addr_q;
            wr_data_s = CLEAR_COLOUR;
        end else begin
            wr_en_s   = plot_ok_s;
        end
    end
`else
    logic unused_clear_s;
    assign unused_clear_s = ^CLEAR_COLOUR;
    assign busy_s         = 1'b0;

    // Write port: plots only
    always_comb begin
        wr_en_s   = plot_ok_s;
        wr_addr_s = plot_addr_s;
        wr_data_s = colour;
    end
`endif

    // Frame buffer: read-before-write, read launched in the ph=0 cycle
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
        if (!ph_q) begin
            rd_data_q <= mem_q[rd_addr_s];
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    // Timing next state: counters and pin values only move on ticks (ph=1)
    always_comb begin
        ph_d      = ~ph_q;
        h_d       = h_q;
        v_d       = v_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;
        if (ph_q) begin
            if (h_q == H_LAST) begin
                h_d = 10'd0;
                if (v_q == V_LAST) begin
                    v_d = 10'd0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
            // Pin values describe the pre-tick counter position
            hs_d      = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
            vs_d      = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
            blank_n_d = (h_q < H_VIS) && (v_q < V_VIS);
            rgb_d     = blank_n_d ? rd_data_q : 3'b000;
        end else begin
            h_d = h_q;
        end
    end

    // Timing and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ph_q      <= 1'b0;
            h_q       <= 10'd0;
            v_q       <= 10'd0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            rgb_q     <= 3'b000;
        end else begin
            ph_q      <= ph_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign busy        = busy_s;
    assign vga_clk     = ph_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = {10{rgb_q[2]}};
    assign vga_g       = {10{rgb_q[1]}};
    assign vga_b       = {10{rgb_q[0]}};

endmodule

// File: tb/tb_pixel_frame_sink.sv
module tb_pixel_frame_sink;

    logic       clk = 1'b0;
    logic       resetn;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
    logic [9:0] vga_r, vga_g, vga_b;

    int checks = 0;
    int errors = 0;
    logic [2:0] ref_mem [0:19199];

`ifdef FRAME_CLEAR_EN
    localparam logic BUSY_AT_RESET = 1'b1;
`else
    localparam logic BUSY_AT_RESET = 1'b0;
`endif

    pixel_frame_sink #(.CLEAR_COLOUR(3'b010)) dut (
        .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset for 3 clk and check the reset state; reset is released at a negedge
    task automatic do_reset();
        resetn = 1'b0;
        plot   = 1'b0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'b000;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {59'd0, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n}, 64'h0C);
        check_eq("rst_rgb", {34'd0, vga_r, vga_g, vga_b}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, {63'd0, BUSY_AT_RESET});
        resetn = 1'b1;
    endtask

    // Scan from the frame start, comparing every clk against the position model
    task automatic scan(input int lines, input bit with_plots);
        int hs_low = 0;
        int blank_hi = 0;
        for (int n = 1; n <= lines * 1600; n++) begin
            int k, q, h, v;
            logic [4:0]  e_ctl;
            logic [29:0] e_rgb;
            logic [2:0]  c;
            @(negedge clk);
            k = n / 2;
            if (k == 0) begin
                e_ctl = {1'(n % 2), 4'b1100};
                e_rgb = 30'd0;
            end else begin
                q = k - 1;
                h = q % 800;
                v = (q / 800) % 525;
                e_ctl[4] = 1'(n % 2);
                e_ctl[3] = !(h >= 656 && h < 752);
                e_ctl[2] = !(v >= 490 && v < 492);
                e_ctl[1] = (h < 640) && (v < 480);
                e_ctl[0] = 1'b0;
                if (e_ctl[1]) begin
                    c = ref_mem[(v / 4) * 160 + h / 4];
                    e_rgb = {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
                end else begin
                    e_rgb = 30'd0;
                end
            end
            check_eq("ctl", {59'd0, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n}, {59'd0, e_ctl});
            check_eq("rgb", {34'd0, vga_r, vga_g, vga_b}, {34'd0, e_rgb});
`ifndef FRAME_CLEAR_EN
            if (n == 2) check_eq("pix00", {34'd0, vga_r, vga_g, vga_b}, {34'd0, 30'h3FF003FF});
`endif
            if (vga_hs == 1'b0) hs_low++;
            if (vga_blank_n == 1'b1) blank_hi++;
            if (n % 1600 == 0) begin
                check_eq("hs_low_per_line", hs_low, 64'd192);
                check_eq("blank_hi_per_line", blank_hi, 64'd1280);
                hs_low = 0;
                blank_hi = 0;
            end
            plot = 1'b0;
            if (with_plots && n < 6000) begin
                case (n % 7)
                    0: begin
                        x = 8'($urandom_range(0, 159));
                        y = 7'($urandom_range(4, 5));
                        colour = 3'($urandom_range(0, 7));
                        plot = 1'b1;
                        ref_mem[int'(y) * 160 + int'(x)] = colour;
                    end
                    3: begin
                        x = 8'($urandom_range(160, 255));
                        y = 7'($urandom_range(0, 4));
                        colour = 3'b111;
                        plot = 1'b1;
                    end
                    5: begin
                        x = 8'($urandom_range(0, 159));
                        y = 7'($urandom_range(120, 127));
                        colour = 3'b111;
                        plot = 1'b1;
                    end
                    default: plot = 1'b0;
                endcase
            end
        end
        plot = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        plot   = 1'b0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'b000;
        @(negedge clk);
`ifdef FRAME_CLEAR_EN
        begin
            int cnt = 0;
            do_reset();
            while (cnt < 30000) begin
                @(negedge clk);
                cnt++;
                plot = 1'b0;
                if (busy == 1'b0) break;
                if (cnt == 10000) begin
                    x = 8'd5;
                    y = 7'd5;
                    colour = 3'b111;
                    plot = 1'b1;
                end
            end
            plot = 1'b0;
            check_eq("busy_len", cnt, 64'd19200);
            for (int a = 0; a < 19200; a++) ref_mem[a] = 3'b010;
            do_reset();
            scan(24, 1'b0);
        end
`else
        do_reset();
        for (int a = 0; a < 19200; a++) begin
            x = 8'(a % 160);
            y = 7'(a / 160);
            colour = (a == 0) ? 3'b101 : 3'($urandom_range(0, 7));
            ref_mem[a] = colour;
            plot = 1'b1;
            @(negedge clk);
        end
        check_eq("busy_run", {63'd0, busy}, 64'd0);
        // Out-of-range plots must be dropped
        plot = 1'b1; colour = 3'b111;
        x = 8'd160; y = 7'd0;   @(negedge clk);
        x = 8'd0;   y = 7'd120; @(negedge clk);
        x = 8'd255; y = 7'd2;   @(negedge clk);
        plot = 1'b0;
        @(negedge clk);
        do_reset();
        scan(24, 1'b1);
        check_eq("busy_end", {63'd0, busy}, 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
